// File: rtl/fifo_sc_hs_reg_based_pkg.sv
// rtl/fifo_sc_hs_reg_based_pkg.sv - shared helpers for the register-based handshake FIFO
package fifo_sc_hs_reg_based_pkg;

  // Ceiling log2, never below 1 so a 2-entry array still gets a 1-bit address.
  function automatic int func_log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic hs_fire(input logic val, input logic rdy);
    return val & rdy;
  endfunction

endpackage

// File: rtl/fifo_sc_hs_reg_based_if.sv
// rtl/fifo_sc_hs_reg_based_if.sv - handshake bundle between producer/consumer and the FIFO
interface fifo_sc_hs_reg_based_if #(
  parameter int SIZE    = 8,
  parameter int DATA_WD = 32
);
  localparam int SIZE_WD = fifo_sc_hs_reg_based_pkg::func_log2(SIZE);

  logic               flush_i;
  logic               wr_val_i;
  logic               wr_rdy_o;
  logic [DATA_WD-1:0] wr_dat_i;
  logic               rd_val_o;
  logic               rd_rdy_i;
  logic [DATA_WD-1:0] rd_dat_o;
  logic               afull_o;
  logic               aempty_o;
  logic [SIZE_WD:0]   wd_usd_o;

  modport master (
    output flush_i, wr_val_i, wr_dat_i, rd_rdy_i,
    input  wr_rdy_o, rd_val_o, rd_dat_o, afull_o, aempty_o, wd_usd_o
  );

  modport slave (
    input  flush_i, wr_val_i, wr_dat_i, rd_rdy_i,
    output wr_rdy_o, rd_val_o, rd_dat_o, afull_o, aempty_o, wd_usd_o
  );

endinterface

// File: rtl/fifo_sc_hs_reg_based_ptr_wrap.sv
// rtl/fifo_sc_hs_reg_based_ptr_wrap.sv - address counter wrapping at SIZE-1 (any SIZE)
module fifo_sc_hs_reg_based_ptr_wrap import fifo_sc_hs_reg_based_pkg::*; #(
  parameter int SIZE   = 8,
  parameter int ADR_WD = func_log2(SIZE)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [ADR_WD-1:0] o_adr
);

  localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(SIZE - 1);

  logic [ADR_WD-1:0] r_adr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_adr <= '0;
    end else if (i_clr) begin
      r_adr <= '0;
    end else if (i_inc) begin
      r_adr <= (r_adr == LAST_ADR) ? '0 : r_adr + 1'b1;
    end
  end

  assign o_adr = r_adr;

endmodule

// File: rtl/fifo_sc_hs_reg_based.sv
// rtl/fifo_sc_hs_reg_based.sv - single-clock register FIFO, FWFT read with optional output register
module fifo_sc_hs_reg_based import fifo_sc_hs_reg_based_pkg::*; #(
  parameter int SIZE        = 8,
  parameter int DATA_WD     = 32,
  parameter int KNOB_REGOUT = 0,
  parameter int AFULL_LVL   = 6,
  parameter int AEMPT_LVL   = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  fifo_sc_hs_reg_based_if.slave  bus
);

  localparam int SIZE_WD = func_log2(SIZE);
  localparam int CAP     = SIZE + KNOB_REGOUT;

  localparam logic [SIZE_WD:0] CAP_V     = CAP[SIZE_WD:0];
  localparam logic [SIZE_WD:0] AFULL_THR = AFULL_LVL[SIZE_WD:0];
  localparam logic [SIZE_WD:0] AEMPT_THR = AEMPT_LVL[SIZE_WD:0];

  logic [DATA_WD-1:0] r_mem [SIZE];
  logic [SIZE_WD:0]   r_cnt;
  logic [SIZE_WD-1:0] w_wr_adr;
  logic [SIZE_WD-1:0] w_rd_adr;
  logic               w_wr_rdy;
  logic               w_push;
  logic               w_pop;
  logic               w_rd_inc;
  logic               w_rd_val;
  logic [DATA_WD-1:0] w_rd_dat;

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign w_wr_rdy = (r_cnt != CAP_V);
  assign w_push   = hs_fire(bus.wr_val_i, w_wr_rdy) & ~bus.flush_i;
  assign w_pop    = hs_fire(w_rd_val, bus.rd_rdy_i) & ~bus.flush_i;

  fifo_sc_hs_reg_based_ptr_wrap #(.SIZE(SIZE), .ADR_WD(SIZE_WD)) u_wr_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_push),
    .i_clr (bus.flush_i),
    .o_adr (w_wr_adr)
  );

  fifo_sc_hs_reg_based_ptr_wrap #(.SIZE(SIZE), .ADR_WD(SIZE_WD)) u_rd_ptr (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_rd_inc),
    .i_clr (bus.flush_i),
    .o_adr (w_rd_adr)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_adr] <= bus.wr_dat_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (bus.flush_i) begin
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_pop && !w_push) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  if (KNOB_REGOUT != 0) begin : g_regout
    logic               r_ovld;
    logic [DATA_WD-1:0] r_odat;
    logic               w_arr_ne;
    logic               w_load;

    // The count includes the output register, so the array is non-empty when count exceeds it.
    assign w_arr_ne = (r_cnt != {{SIZE_WD{1'b0}}, r_ovld});
    assign w_load   = w_arr_ne & (~r_ovld | w_pop) & ~bus.flush_i;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_ovld <= 1'b0;
        r_odat <= '0;
      end else if (bus.flush_i) begin
        r_ovld <= 1'b0;
      end else if (w_load) begin
        r_ovld <= 1'b1;
        r_odat <= r_mem[w_rd_adr];
      end else if (w_pop) begin
        r_ovld <= 1'b0;
      end
    end

    assign w_rd_inc = w_load;
    assign w_rd_val = r_ovld;
    assign w_rd_dat = r_odat;
  end else begin : g_comb
    assign w_rd_inc = w_pop;
    assign w_rd_val = (r_cnt != '0);
    assign w_rd_dat = r_mem[w_rd_adr];
  end

  assign bus.wr_rdy_o = w_wr_rdy;
  assign bus.rd_val_o = w_rd_val;
  assign bus.rd_dat_o = w_rd_dat;
  assign bus.wd_usd_o = r_cnt;
  assign bus.afull_o  = (r_cnt >= AFULL_THR);
  assign bus.aempty_o = (r_cnt <= AEMPT_THR);

`ifdef SIM_KNOB_DBG
  logic               r_dbg_hold;
  logic [DATA_WD-1:0] r_dbg_dat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dbg_hold <= 1'b0;
      r_dbg_dat  <= '0;
    end else begin
      if (SIZE < 2 || AFULL_LVL > CAP || AEMPT_LVL >= CAP) $finish;
      if (r_dbg_hold && (w_rd_dat != r_dbg_dat)) $finish;
      r_dbg_hold <= w_rd_val & ~bus.rd_rdy_i & ~bus.flush_i;
      r_dbg_dat  <= w_rd_dat;
    end
  end
`endif

endmodule
